// File: rtl/cla_serial_adder.sv
// Nibble-serial WIDTH-bit adder around a single 4-bit carry-lookahead stage.
// Define CLA_SERIAL_SUB_EN to add the op_sub port (A - B via ~B + 1).

module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one nibble per cycle through the cla, LSB first
// DONE  | out_valid=1, result held until out_ready
module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             result_ovf
);
  localparam int N  = WIDTH / 4;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [SW-1:0]    step;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             a_msb, b_msb;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [3:0]       cla_sum;
  logic             cla_cout;
  logic [WIDTH-1:0] sum_top;

`ifdef CLA_SERIAL_SUB_EN
  assign b_eff   = op_sub ? ~op_b : op_b;
  assign cin_eff = op_sub ? 1'b1 : op_cin;
`else
  assign b_eff   = op_b;
  assign cin_eff = op_cin;
`endif

  cla u_cla (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // New nibble enters at the top so after N shifts nibble 0 sits at the bottom.
  assign sum_top = WIDTH'(cla_sum) << (WIDTH - 4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      step   <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= op_a;
            b_sh  <= b_eff;
            carry <= cin_eff;
            a_msb <= op_a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            step  <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          res_sh <= (res_sh >> 4) | sum_top;
          carry  <= cla_cout;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          step   <= step + 1'b1;
          if (step == LAST) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state == S_IDLE);
  assign out_valid   = (state == S_DONE);
  assign result      = res_sh;
  assign result_cout = carry;
  assign result_ovf  = (a_msb == b_msb) && (res_sh[WIDTH-1] != a_msb);
endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder (WIDTH=16): directed table, corner
// sequences and randomized operands against an integer-arithmetic model.

module tb_cla_serial_adder;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a, op_b;
  logic          op_cin;
  logic          op_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          result_cout;
  logic          result_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  cla_serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
`ifdef CLA_SERIAL_SUB_EN
    .op_sub      (op_sub),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_cout (result_cout),
    .result_ovf  (result_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the effective operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output logic [W-1:0] r, output logic co,
                       output logic ov);
    logic [W-1:0] beff;
    logic         c;
    logic [W:0]   full;
    int           s;
    beff = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, c};
    s    = int'($signed(a)) + int'($signed(beff)) + int'(c);
    r    = full[W-1:0];
    co   = full[W];
    ov   = (s > 32767) || (s < -32768);
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub);
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    op_sub   = sub;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic ir_seen);
    lat     = 0;
    ir_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_seen = 1'b1;
      tick();
      lat++;
    end
    chk("done_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] r, input logic co,
                              input logic ov);
    chk({tag, "_result"}, {16'b0, result}, {16'b0, r});
    chk({tag, "_cout"}, {31'b0, result_cout}, {31'b0, co});
    chk({tag, "_ovf"}, {31'b0, result_ovf}, {31'b0, ov});
  endtask

  initial begin
    vec_t         vecs[$];
    int           lat;
    logic         ir_seen;
    logic [W-1:0] er;
    logic         ec, eo;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;

    // Reset state
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_cout", {31'b0, result_cout}, 32'd0);
    chk("rst_ovf", {31'b0, result_ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
`ifdef CLA_SERIAL_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done(lat, ir_seen);
      chk($sformatf("vec%0d_latency", i), lat, 32'd4);
      chk($sformatf("vec%0d_in_ready_busy", i), {31'b0, ir_seen | in_ready}, 32'd0);
      check_result($sformatf("vec%0d", i), vecs[i].res, vecs[i].cout, vecs[i].ovf);
      release_out();
      chk($sformatf("vec%0d_idle_after", i), {30'b0, in_ready, out_valid}, 32'd2);
    end

    // Stall in DONE with input activity: nothing accepted, outputs stable
    accept(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done(lat, ir_seen);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      op_cin   = 1'($urandom);
      tick();
      chk($sformatf("hold%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      check_result($sformatf("hold%0d", k), 16'h2345, 1'b0, 1'b0);
    end
    in_valid = 1'b1;
    release_out();
    in_valid = 1'b0;
    chk("hold_release_idle", {30'b0, in_ready, out_valid}, 32'd2);
    accept(16'h0100, 16'h0ABC, 1'b1, 1'b0);
    wait_done(lat, ir_seen);
    check_result("after_hold", 16'h0BBD, 1'b0, 1'b0);
    release_out();

    // Reset in the middle of RUN discards the operation
    accept(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", {16'b0, result}, 32'd0);
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) lat++;
      tick();
    end
    chk("midrst_no_output", lat, 32'd0);
    accept(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_done(lat, ir_seen);
    chk("midrst_fresh_latency", lat, 32'd4);
    check_result("midrst_fresh", 16'h0003, 1'b0, 1'b0);
    release_out();

    // Randomized operands against the model, variable consumer delay
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef CLA_SERIAL_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      model(ra, rb, rc, rs, er, ec, eo);
      accept(ra, rb, rc, rs);
      wait_done(lat, ir_seen);
      if (lat != 4) chk($sformatf("rnd%0d_latency", i), lat, 32'd4);
      repeat ($urandom_range(0, 2)) tick();
      check_result($sformatf("rnd%0d", i), er, ec, eo);
      release_out();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
